// File: rtl/chip8_sound_ctrl.sv
// CHIP-8 sound timer and envelope controller: 60 Hz sound timer plus a volume gate for the audio path.
// Define CHIP8_SOUND_FADE_EN to enable the ATTACK/RELEASE volume ramps; otherwise the gate is hard on/off.
module chip8_sound_ctrl #(
    parameter int unsigned CLK_HZ   = 100_000_000,
    parameter int unsigned TICK_HZ  = 60,
    parameter int unsigned RAMP_DIV = 100_000
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       st_we_in,
    input  logic [7:0] st_data_in,
    input  logic       cfg_we_in,
    input  logic [6:0] cfg_data_in,
    input  logic       pause_in,
    output logic       active_out,
    output logic [1:0] timbre_out,
    output logic [1:0] pitch_out,
    output logic [2:0] vol_out,
    output logic [7:0] st_out,
    output logic       tick_out
);

    localparam int unsigned TICK_DIV = CLK_HZ / TICK_HZ;
    localparam int unsigned TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

    typedef enum logic [1:0] {StIdle, StAttack, StSustain, StRelease} state_e;

    state_e        state_q;
    logic [TW-1:0] tick_cnt_q;
    logic [7:0]    st_q;
    logic [2:0]    vol_q;
    logic [2:0]    target_q;
    logic [2:0]    target_d;
    logic [1:0]    sh_timbre_q;
    logic [1:0]    sh_pitch_q;
    logic [1:0]    timbre_q;
    logic [1:0]    pitch_q;
    logic          tick;
    logic          sound_on;

    assign tick     = !pause_in && (tick_cnt_q == TICK_LAST);
    assign sound_on = (st_q != 8'd0) && !pause_in;
    assign target_d = cfg_we_in ? cfg_data_in[2:0] : target_q;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            tick_cnt_q <= '0;
        end else if (!pause_in) begin
            tick_cnt_q <= tick ? '0 : tick_cnt_q + 1'b1;
        end
    end

    // A CPU write in the tick cycle takes priority over the decrement.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            st_q <= 8'd0;
        end else if (st_we_in) begin
            st_q <= st_data_in;
        end else if (tick && (st_q != 8'd0)) begin
            st_q <= st_q - 8'd1;
        end
    end

    // Timbre/pitch only propagate while silent so a tone never changes character mid-note.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            target_q    <= 3'd7;
            sh_timbre_q <= 2'd0;
            sh_pitch_q  <= 2'd0;
            timbre_q    <= 2'd0;
            pitch_q     <= 2'd0;
        end else begin
            target_q <= target_d;
            if (cfg_we_in) begin
                sh_timbre_q <= cfg_data_in[6:5];
                sh_pitch_q  <= cfg_data_in[4:3];
            end
            if (state_q == StIdle) begin
                timbre_q <= sh_timbre_q;
                pitch_q  <= sh_pitch_q;
            end
        end
    end

`ifdef CHIP8_SOUND_FADE_EN
    localparam int unsigned RW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam logic [RW-1:0] RAMP_LAST = RW'(RAMP_DIV - 1);

    logic [RW-1:0] ramp_q;
    logic          step;
    logic [2:0]    vol_toward;

    assign step = (ramp_q == RAMP_LAST);

    always_comb begin
        vol_toward = vol_q;
        if (vol_q < target_q) begin
            vol_toward = vol_q + 3'd1;
        end else if (vol_q > target_q) begin
            vol_toward = vol_q - 3'd1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q <= StIdle;
            vol_q   <= 3'd0;
            ramp_q  <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    vol_q  <= 3'd0;
                    ramp_q <= '0;
                    if (sound_on) begin
                        state_q <= StAttack;
                    end
                end
                StAttack: begin
                    if (!sound_on) begin
                        state_q <= StRelease;
                        ramp_q  <= '0;
                    end else begin
                        ramp_q <= step ? '0 : ramp_q + 1'b1;
                        if (step) begin
                            vol_q <= vol_toward;
                        end
                        if (vol_q >= target_q) begin
                            state_q <= StSustain;
                        end
                    end
                end
                StSustain: begin
                    if (!sound_on) begin
                        state_q <= StRelease;
                        ramp_q  <= '0;
                    end else begin
                        ramp_q <= step ? '0 : ramp_q + 1'b1;
                        if (step) begin
                            vol_q <= vol_toward;
                        end
                    end
                end
                StRelease: begin
                    if (sound_on) begin
                        state_q <= StAttack;
                        ramp_q  <= '0;
                    end else if (vol_q == 3'd0) begin
                        state_q <= StIdle;
                    end else begin
                        ramp_q <= step ? '0 : ramp_q + 1'b1;
                        if (step) begin
                            vol_q <= vol_q - 3'd1;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end
`else
    logic unused_ramp_div;
    assign unused_ramp_div = (RAMP_DIV == 0);

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q <= StIdle;
            vol_q   <= 3'd0;
        end else begin
            state_q <= sound_on ? StSustain : StIdle;
            vol_q   <= sound_on ? target_d : 3'd0;
        end
    end
`endif

    assign active_out = (state_q != StIdle);
    assign vol_out    = vol_q;
    assign timbre_out = timbre_q;
    assign pitch_out  = pitch_q;
    assign st_out     = st_q;
    assign tick_out   = tick;

endmodule
